// File: rtl/barrel_pkg.sv
// Shared constants and the port-rotation index helper used by the barrel
// shifter/unshifter datapaths.
package barrel_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int PORT_DEF  = 8;

  // Rotating right by 2^stage ports: output port k takes input port k+2^stage.
  function automatic int rotr_src_port(input int k, input int stage, input int ports);
    return (k + (1 << stage)) % ports;
  endfunction

endpackage

// File: rtl/barrel_unshift_stage.sv
// One register stage of the unshifter: rotates right by 2^STAGE ports when its
// select bit is set, otherwise passes the beat through unchanged.
module barrel_unshift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PORT  = PORT_DEF,
  parameter int STAGE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      vld_i,
  input  logic [$clog2(PORT)-1:0]   sel_i,
  input  logic [WIDTH*PORT-1:0]     data_i,
  output logic                      vld_o,
  output logic [$clog2(PORT)-1:0]   sel_o,
  output logic [WIDTH*PORT-1:0]     data_o
);

  localparam int SEL_W = $clog2(PORT);
  localparam int BUS_W = WIDTH * PORT;

  logic [BUS_W-1:0] rot;
  logic [BUS_W-1:0] data_d;
  logic [BUS_W-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             vld_q;

  for (genvar k = 0; k < PORT; k++) begin : g_port
    localparam int SRC = rotr_src_port(k, STAGE, PORT);
    assign rot[k*WIDTH +: WIDTH] = data_i[SRC*WIDTH +: WIDTH];
  end

  assign data_d = sel_i[STAGE] ? rot : data_i;

  // Data only moves with a real beat so a stalled or drained slot keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (en_i) begin
      vld_q <= vld_i;
      if (vld_i) begin
        sel_q  <= sel_i;
        data_q <= data_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign sel_o  = sel_q;
  assign data_o = data_q;

endmodule

// File: rtl/barrel_unshifter_pipe.sv
// Pipelined port-granular barrel unshifter with valid/ready flow control.
// Optional output-transfer counter enabled by defining BARREL_UNSHIFT_CNT_EN.
module barrel_unshifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PORT  = PORT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [$clog2(PORT)-1:0]   select,
  input  logic [WIDTH*PORT-1:0]     data_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [WIDTH*PORT-1:0]     data_out
`ifdef BARREL_UNSHIFT_CNT_EN
  ,
  output logic [31:0]               beat_cnt
`endif
);

  localparam int SEL_W = $clog2(PORT);
  localparam int BUS_W = WIDTH * PORT;

  logic [SEL_W:0]   vld_a;
  logic [SEL_W-1:0] en;
  logic [BUS_W-1:0] data_a [SEL_W+1];
  logic [SEL_W-1:0] sel_a  [SEL_W+1];

  assign vld_a[0]  = valid_in;
  assign data_a[0] = data_in;
  assign sel_a[0]  = select;

  for (genvar s = 0; s < SEL_W; s++) begin : g_stage
    // A stage may load unless it and every stage after it are full and the sink stalls.
    assign en[s] = ready_out | ~(&vld_a[SEL_W:s+1]);

    barrel_unshift_stage #(
      .WIDTH (WIDTH),
      .PORT  (PORT),
      .STAGE (s)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en[s]),
      .vld_i  (vld_a[s]),
      .sel_i  (sel_a[s]),
      .data_i (data_a[s]),
      .vld_o  (vld_a[s+1]),
      .sel_o  (sel_a[s+1]),
      .data_o (data_a[s+1])
    );
  end

  assign ready_in  = en[0];
  assign valid_out = vld_a[SEL_W];
  assign data_out  = data_a[SEL_W];

`ifdef BARREL_UNSHIFT_CNT_EN
  logic [31:0] beat_cnt_q;
  logic [31:0] beat_cnt_d;

  assign beat_cnt_d = (valid_out && ready_out) ? beat_cnt_q + 32'd1 : beat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: doc/barrel_unshifter_pipe.md
Name: barrel_unshifter_pipe

Overview:
Pipelined inverse of the port-granular barrel shifter. Takes a WIDTH*PORT bus that upstream rotated left by select ports, and restores the original port order. Uses one register stage per select bit, with valid/ready flow control. Sits at the receive end of the rotated-data path, undoing the lane rotation before data reaches per-port consumers.

Parameters:
WIDTH, 64, width of one port in bits
PORT, 8, number of ports; power of two, >= 2
SEL_W, $clog2(PORT), select width; also the pipeline depth
BUS_W, WIDTH*PORT, total bus width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  beat presented on data_in/select
ready_in  output  1  block accepts beat this cycle
select  input  SEL_W  rotation amount (ports) applied upstream
data_in  input  BUS_W  rotated bus; port p = bits [p*WIDTH +: WIDTH]
valid_out  output  1  data_out holds a restored beat
ready_out  input  1  downstream accepts beat
data_out  output  BUS_W  de-rotated bus

Behaviour:
- Upstream mapping (decided): original port p appears on port (p+select) mod PORT.
- Unshift: data_out port k = data_in port (k+select) mod PORT, i.e. rotate right by select*WIDTH bits.
- Pipeline: SEL_W stages, S0..S(SEL_W-1). Stage s holds valid_s, data_s, and the remaining select bits.
- Stage s rotates right by 2^s ports when select bit s is 1; otherwise passes data unchanged.
- Stage s loads when its slot is free or draining: en_s = !valid_s | en_(s+1). The last stage uses ready_out in place of en_(s+1).
- ready_in = en_0. The combinational ready chain is allowed; no skid buffers.
- Transfer in: valid_in & ready_in. Transfer out: valid_out & ready_out. valid_out = valid of the last stage.
- Latency: SEL_W cycles from accept to valid_out, with no stall. Throughput: 1 beat/cycle when ready_out is held high.
- Stall: when ready_out=0 with the last stage full, data_out and valid_out hold stable. Bubbles ahead still compact (a stage loads into an empty slot).
- Ordering: strictly in order. No beat is dropped or duplicated except by reset.
- Reset: all valid_s=0, all data_s=0, so valid_out=0 and data_out=0. ready_in=1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight beats are discarded. Inputs during rst=1 are ignored.
- select=0: output equals input, delayed. select=PORT-1: output port k = input port (k-1) mod PORT.
- No arithmetic overflow: rotation indices are mod PORT and formed by bit slicing.

Optional Feature:
Macro BARREL_UNSHIFT_CNT_EN.
- Defined: adds output beat_cnt [31:0], the count of output transfers. Reset to 0; increments by 1 on each valid_out & ready_out; wraps from 0xFFFFFFFF to 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package barrel_pkg: default WIDTH/PORT constants, and a rotate-right-by-2^s-ports function shared with the forward shifter's model.
- One natural sub-module: barrel_unshift_stage. It holds one register stage with parameter STAGE (rotation 2^STAGE ports), and is instantiated SEL_W times in a generate loop.

Test Plan:
1. WIDTH=64, PORT=8, port p of original = p. Rotate by select=3 and drive one beat with ready_out=1 -> valid_out exactly 3 cycles later; data_out port k = k for all k.
2. Back-to-back: 16 beats, select sweeping 0..7 twice, ready_out=1 -> 16 outputs on consecutive cycles, in order, each matching its original.
3. Backpressure: ready_out=0 for 10 cycles while sending 5 beats -> ready_in drops after 3 beats accepted; data_out stable throughout; all 5 beats emerge in order after ready_out=1.
4. Reset mid-flight: 2 beats in the pipe, assert rst for 1 cycle -> valid_out=0 and data_out=0 next cycle; no stale beat ever emerges.
5. Boundary selects: select=0 -> passthrough; select=7 -> data_out port 0 = data_in port 7; random data, 1000 beats, random ready_out, checked against a reference model.
6. With BARREL_UNSHIFT_CNT_EN: 20 outputs -> beat_cnt=20; force the counter to 0xFFFFFFFF then one transfer -> beat_cnt=0.
